// File: rtl/clock_enables.sv
// rtl/clock_enables.sv - programmable per-channel clock-enable pulses and toggle levels
// Single clock domain: downstream logic qualifies master_clock with ce/level, no derived clocks.
module clock_enables #(
   parameter int                        CHANNELS  = 4,
   parameter int                        WIDTH     = 16,
   parameter logic [CHANNELS*WIDTH-1:0] RESET_DIV = {4{16'd1}}
) (
   input  logic                master_clock,
   input  logic                master_reset_n,
   output logic                fpga_clock_a,
   input  logic                wr_en,
   input  logic [2:0]          wr_chan,
   input  logic [WIDTH-1:0]    wr_div,
   input  logic                resync,
   input  logic [2:0]          rd_chan,
   output logic [WIDTH-1:0]    rd_div,
   output logic [CHANNELS-1:0] ce,
   output logic [CHANNELS-1:0] level
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0]    pend [CHANNELS];
   logic [WIDTH-1:0]    act  [CHANNELS];
   logic [WIDTH-1:0]    cnt  [CHANNELS];
   logic [CHANNELS-1:0] wr_hit;

   // A divisor of 0 parks the counter at 0 so ce stays low.
   function automatic logic [WIDTH-1:0] first_cnt(input logic [WIDTH-1:0] d);
      return (d == '0) ? '0 : d - ONE;
   endfunction

   assign fpga_clock_a = master_clock;

   always_comb begin
      rd_div = '0;
      wr_hit = '0;
      ce     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = wr_en && (wr_chan == 3'(i));
         ce[i]     = (act[i] != '0) && (cnt[i] == '0);
         if (rd_chan == 3'(i)) rd_div = act[i];
      end
   end

   always_ff @(posedge master_clock or negedge master_reset_n) begin
      if (!master_reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            pend[i]  <= RESET_DIV[i*WIDTH +: WIDTH];
            act[i]   <= RESET_DIV[i*WIDTH +: WIDTH];
            cnt[i]   <= first_cnt(RESET_DIV[i*WIDTH +: WIDTH]);
            level[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit[i]) pend[i] <= wr_div;
            if (ce[i]) level[i] <= ~level[i];
            // Resync outranks the natural wrap and sees a same-edge write.
            if (resync) begin
               act[i] <= wr_hit[i] ? wr_div : pend[i];
               cnt[i] <= first_cnt(wr_hit[i] ? wr_div : pend[i]);
            end else if (act[i] == '0) begin
               if (wr_hit[i]) begin
                  act[i] <= wr_div;
                  cnt[i] <= first_cnt(wr_div);
               end else begin
                  cnt[i] <= '0;
               end
            end else if (cnt[i] == '0) begin
               act[i] <= pend[i];
               cnt[i] <= first_cnt(pend[i]);
            end else begin
               cnt[i] <= cnt[i] - ONE;
            end
         end
      end
   end

endmodule
